leaf_index_queue: RTL and testbench

LEAF_INDEX_QUEUE -- requirements
Module: leaf_index_queue

---
 rtl/leaf_index_queue.sv | 111 +++++++++++
 tb/tb_leaf_index_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/leaf_index_queue.sv
// Dual-lane leaf index queue: merges two tree result lanes into one tagged FIFO
// feeding the leaf memory read port, with almost_full backpressure and a sticky overflow flag.
module leaf_index_queue #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned TAG_WIDTH     = 10,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned AF_MARGIN     = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       receiver_en,
  input  logic [ADDRESS_WIDTH-1:0]   leaf_index,
  input  logic                       receiver_two_en,
  input  logic [ADDRESS_WIDTH-1:0]   leaf_index_two,
  input  logic                       query_start,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDRESS_WIDTH-1:0]   out_leaf_addr,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic                       out_lane,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  typedef struct packed {
    logic                     lane;
    logic [TAG_WIDTH-1:0]     tag;
    logic [ADDRESS_WIDTH-1:0] idx;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot_b;
  logic [TAG_WIDTH-1:0] tag_a_q, tag_a_d, tag_b_q, tag_b_d, tag_a_use, tag_b_use;
  logic                 overflow_q, overflow_d;
  logic                 out_valid_q, almost_full_q;
  logic [CNT_W-1:0]     free;
  logic                 wr_a, wr_b, pop, drop;
  entry_t               entry_a, entry_b, head;

  // Admission, pointer and tag next-state; free space is taken before any same-cycle pop.
  always_comb begin
    free       = CNT_W'(DEPTH) - count_q;
    wr_a       = !flush && receiver_en && (free >= CNT_W'(1));
    wr_b       = !flush && receiver_two_en && (free >= (wr_a ? CNT_W'(2) : CNT_W'(1)));
    pop        = !flush && (count_q != '0) && out_ready;
    drop       = !flush && ((receiver_en && !wr_a) || (receiver_two_en && !wr_b));
    tag_a_use  = query_start ? '0 : tag_a_q;
    tag_b_use  = query_start ? '0 : tag_b_q;
    tag_a_d    = tag_a_use + TAG_WIDTH'(receiver_en);
    tag_b_d    = tag_b_use + TAG_WIDTH'(receiver_two_en);
    entry_a    = '{lane: 1'b0, tag: tag_a_use, idx: leaf_index};
    entry_b    = '{lane: 1'b1, tag: tag_b_use, idx: leaf_index_two};
    slot_b     = wr_ptr_q + PTR_W'(wr_a);
    count_d    = count_q + CNT_W'(wr_a) + CNT_W'(wr_b) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_a) + PTR_W'(wr_b);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    overflow_d = overflow_q | drop;
    if (flush) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_a_q       <= '0;
      tag_b_q       <= '0;
      overflow_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_a_q       <= tag_a_d;
      tag_b_q       <= tag_b_d;
      overflow_q    <= overflow_d;
      out_valid_q   <= (count_d != '0);
      almost_full_q <= (count_d >= CNT_W'(AF_LEVEL));
    end
  end

  // Storage needs no reset; lane one always lands ahead of lane two.
  always_ff @(posedge clk) begin
    if (wr_a) mem_q[wr_ptr_q] <= entry_a;
    if (wr_b) mem_q[slot_b]   <= entry_b;
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_valid     = out_valid_q;
  assign out_leaf_addr = head.idx;
  assign out_tag       = head.tag;
  assign out_lane      = head.lane;
  assign almost_full   = almost_full_q;
  assign overflow      = overflow_q;
  assign count         = count_q;

endmodule

// File: tb/tb_leaf_index_queue.sv
// Scoreboard bench for leaf_index_queue: stimulus pushes expected entries, a negedge monitor pops on every handshake.
module tb_leaf_index_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       receiver_en = 1'b0, receiver_two_en = 1'b0;
  logic [7:0] leaf_index = '0, leaf_index_two = '0;
  logic       query_start = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic       out_valid, out_lane, almost_full, overflow;
  logic [7:0] out_leaf_addr;
  logic [9:0] out_tag;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;
  logic [18:0] sbq [$];
  logic [9:0]  ta = '0, tb = '0;

  leaf_index_queue #(.ADDRESS_WIDTH(8), .TAG_WIDTH(10), .DEPTH(32), .AF_MARGIN(14)) dut (
    .clk(clk), .rst(rst),
    .receiver_en(receiver_en), .leaf_index(leaf_index),
    .receiver_two_en(receiver_two_en), .leaf_index_two(leaf_index_two),
    .query_start(query_start), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_leaf_addr(out_leaf_addr), .out_tag(out_tag), .out_lane(out_lane),
    .almost_full(almost_full), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      logic [18:0] got, req;
      got = {out_lane, out_tag, out_leaf_addr};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got lane %0d tag %0d addr %0d with empty scoreboard",
                 out_lane, out_tag, out_leaf_addr);
      end else begin
        req = sbq.pop_front();
        if (got !== req) begin
          errors++;
          $display("FAIL pop_entry: got lane %0d tag %0d addr %0d expected lane %0d tag %0d addr %0d",
                   got[18], got[17:8], got[7:0], req[18], req[17:8], req[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One input cycle; sa/sb say whether each lane's entry is expected to be stored.
  task automatic cyc(input logic ea, input logic [7:0] ia, input logic eb, input logic [7:0] ib,
                     input logic qs, input logic fl, input logic sa, input logic sb);
    logic [9:0] tga, tgb;
    tga = qs ? 10'd0 : ta;
    tgb = qs ? 10'd0 : tb;
    ta  = tga + 10'(ea);
    tb  = tgb + 10'(eb);
    if (fl) sbq.delete();
    if (sa) sbq.push_back({1'b0, tga, ia});
    if (sb) sbq.push_back({1'b1, tgb, ib});
    receiver_en = ea; leaf_index = ia;
    receiver_two_en = eb; leaf_index_two = ib;
    query_start = qs; flush = fl;
    step();
    receiver_en = 1'b0; receiver_two_en = 1'b0;
    query_start = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64 && count != '0; i++) step();
    chk("drain_count", 32'(count), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    step();

    // Single lane-one entry, one-cycle latency, immediate pop.
    out_ready = 1'b1;
    cyc(1, 8'd5, 0, 8'd0, 0, 0, 1, 0);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_addr", 32'(out_leaf_addr), 5);
    chk("lat_tag", 32'(out_tag), 0);
    chk("lat_lane", 32'(out_lane), 0);
    step();
    chk("lat_count_after_pop", 32'(count), 0);

    // Dual write ordering with query_start restarting both tags; head held while not ready.
    out_ready = 1'b0;
    cyc(1, 8'd3, 1, 8'd9, 1, 0, 1, 1);
    chk("dual_count", 32'(count), 2);
    step();
    chk("hold_addr", 32'(out_leaf_addr), 3);
    chk("hold_lane", 32'(out_lane), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("dual_second_addr", 32'(out_leaf_addr), 9);
    chk("dual_second_lane", 32'(out_lane), 1);
    chk("dual_second_tag", 32'(out_tag), 0);
    drain();

    // Fill to full, watch almost_full, then one fully dropped dual write.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 1, 8'(100 + i), (i == 0), 0, 1, 1);
      chk("fill_count", 32'(count), 32'(2 * (i + 1)));
      chk("fill_af", 32'(almost_full), 32'((2 * (i + 1)) >= 18));
      chk("fill_ovf", 32'(overflow), 0);
    end
    cyc(1, 8'd200, 1, 8'd201, 0, 0, 0, 0);
    chk("full_count", 32'(count), 32);
    chk("full_ovf", 32'(overflow), 1);

    // Flush clears everything; the next tags show both counters advanced to 17.
    cyc(0, 8'd0, 0, 8'd0, 0, 1, 0, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_af", 32'(almost_full), 0);
    cyc(1, 8'd7, 1, 8'd8, 0, 0, 1, 1);
    chk("tag17_head", 32'(out_tag), 17);

    // Reach 31, then a dual write stores lane one only.
    for (int i = 0; i < 14; i++) cyc(1, 8'(40 + i), 1, 8'(60 + i), 0, 0, 1, 1);
    cyc(1, 8'd90, 0, 8'd0, 0, 0, 1, 0);
    chk("c31_count", 32'(count), 31);
    chk("c31_ovf", 32'(overflow), 0);
    cyc(1, 8'd91, 1, 8'd92, 0, 0, 1, 0);
    chk("c32_count", 32'(count), 32);
    chk("c32_ovf", 32'(overflow), 1);
    drain();

    // Flush colliding with a lane-one write at count 10.
    for (int i = 0; i < 5; i++) cyc(1, 8'(120 + i), 1, 8'(140 + i), 0, 0, 1, 1);
    chk("c10_count", 32'(count), 10);
    cyc(1, 8'd77, 0, 8'd0, 0, 1, 0, 0);
    chk("fw_count", 32'(count), 0);
    chk("fw_valid", 32'(out_valid), 0);
    chk("fw_ovf", 32'(overflow), 0);
    cyc(1, 8'd78, 0, 8'd0, 0, 0, 1, 0);
    chk("fw_next_tag", 32'(out_tag), 40);
    drain();

    // Streaming dual writes while popping; the last dual write straddles slot 31 -> 0.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1, 8'(160 + i), 1, 8'(180 + i), 0, 0, 1, 1);
    chk("stream_count", 32'(count), 17);
    drain();

    // Asynchronous reset mid-cycle with 7 entries held.
    for (int i = 0; i < 3; i++) cyc(1, 8'(210 + i), 1, 8'(220 + i), 0, 0, 0, 0);
    cyc(1, 8'd230, 0, 8'd0, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 7);
    #3;
    rst = 1'b1;
    sbq.delete();
    ta = '0;
    tb = '0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_af", 32'(almost_full), 0);
    step();
    rst = 1'b0;
    cyc(1, 8'd55, 1, 8'd56, 0, 0, 1, 1);
    chk("post_rst_tag", 32'(out_tag), 0);
    chk("post_rst_addr", 32'(out_leaf_addr), 55);
    drain();
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
